// File: rtl/bnn_load_ctrl.sv
// Nibble-serial weight loader: assembles NUM_NEURONS 8-bit words from low/high nibble pairs.
// Optional running XOR checksum of written words enabled with `define BNN_LOAD_CKSUM_EN.
module bnn_load_ctrl #(
  parameter int unsigned NUM_NEURONS = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic       load_en,
  input  logic [3:0] nib_in,
  output logic       wr_en,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] cksum
);

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned NW = 4;
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic [NW-1:0] lo_buf;

`ifdef BNN_LOAD_CKSUM_EN
  logic [DW-1:0] cksum_q;
  assign cksum = cksum_q;
`else
  assign cksum = '0;
`endif

  // Load sequencer; outputs registered, wr_en/done are single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      lo_buf  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef BNN_LOAD_CKSUM_EN
      cksum_q <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      if (ena) begin
        if (start) begin
          // Start always wins: fresh sequence at word 0, partial nibble dropped.
          state  <= S_LO;
          busy   <= 1'b1;
          cnt    <= '0;
          lo_buf <= '0;
          err    <= 1'b0;
`ifdef BNN_LOAD_CKSUM_EN
          cksum_q <= '0;
`endif
        end else begin
          case (state)
            S_IDLE, S_DONE: begin
              state <= S_IDLE;
              if (load_en) err <= 1'b1;
            end
            S_LO: begin
              if (load_en) begin
                lo_buf <= nib_in;
                state  <= S_HI;
              end
            end
            S_HI: begin
              if (load_en) begin
                wr_en   <= 1'b1;
                wr_addr <= cnt;
                wr_data <= {nib_in, lo_buf};
`ifdef BNN_LOAD_CKSUM_EN
                cksum_q <= cksum_q ^ {nib_in, lo_buf};
`endif
                if (cnt == LAST_IDX) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  cnt   <= '0;
                end else begin
                  state <= S_LO;
                  cnt   <= cnt + AW'(1);
                end
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bnn_load_ctrl.sv
// Bench for bnn_load_ctrl: nibble-count reference model compared every cycle plus directed literal checks.
module tb_bnn_load_ctrl;

  localparam int unsigned N = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic       load_en = 1'b0;
  logic [3:0] nib_in = 4'h0;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] cksum;

  bnn_load_ctrl #(.NUM_NEURONS(N)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .load_en(load_en),
    .nib_in(nib_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .cksum(cksum)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a sequence is just a count of accepted nibbles; odd ones complete a word.
  bit         m_active = 1'b0;
  int         m_nib = 0;
  logic [3:0] m_lo = 4'h0;
  logic       m_err = 1'b0;
  logic [7:0] m_ck = 8'h00;
  logic [3:0] m_addr = 4'h0;
  logic [7:0] m_data = 8'h00;
  logic       m_wr = 1'b0;
  logic       m_done = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 1'b0; m_nib = 0; m_lo = 4'h0; m_err = 1'b0; m_ck = 8'h00;
      m_addr = 4'h0; m_data = 8'h00; m_wr = 1'b0; m_done = 1'b0;
    end else begin
      m_wr = 1'b0;
      m_done = 1'b0;
      if (ena) begin
        if (start) begin
          m_active = 1'b1; m_nib = 0; m_lo = 4'h0; m_err = 1'b0; m_ck = 8'h00;
        end else if (load_en) begin
          if (!m_active) m_err = 1'b1;
          else if (m_nib % 2 == 0) begin
            m_lo = nib_in;
            m_nib++;
          end else begin
            m_addr = 4'(m_nib / 2);
            m_data = {nib_in, m_lo};
            m_wr = 1'b1;
            m_ck = m_ck ^ m_data;
            m_nib++;
            if (m_nib == 2 * N) begin
              m_active = 1'b0;
              m_done = 1'b1;
            end
          end
        end
      end
    end
  end

  logic [3:0] log_addr[$];
  logic [7:0] log_data[$];
  int         done_cnt = 0;

  function automatic logic [23:0] outs();
    return {wr_en, wr_addr, wr_data, busy, done, err, cksum};
  endfunction

  // Per-cycle compare, sampled on the falling edge.
  initial forever begin
    logic [7:0] eck;
    @(negedge clk);
`ifdef BNN_LOAD_CKSUM_EN
    eck = m_ck;
`else
    eck = 8'h00;
`endif
    check("cycle", 32'(outs()), 32'({m_wr, m_addr, m_data, m_active, m_done, m_err, eck}));
    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
    if (done) done_cnt++;
  end

  task automatic step(input logic s, input logic l, input logic [3:0] n, input logic e);
    start = s; load_en = l; nib_in = n; ena = e;
    @(posedge clk);
    #2;
  endtask

  task automatic load_word(input logic [7:0] w);
    step(1'b0, 1'b1, w[3:0], 1'b1);
    step(1'b0, 1'b1, w[7:4], 1'b1);
  endtask

  logic [7:0] tab [12] = '{8'hA0, 8'h41, 8'hB2, 8'h73, 8'hC4, 8'h15,
                           8'hD6, 8'h37, 8'hE8, 8'h59, 8'hFA, 8'h0B};
  logic [7:0] exp_full_ck;
  int base;

  initial begin
`ifdef BNN_LOAD_CKSUM_EN
    exp_full_ck = 8'h50;
`else
    exp_full_ck = 8'h00;
`endif
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", 32'(outs()), 32'h0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 4'h0, 1'b1);

    // load_en while idle flags a protocol error, no write
    step(1'b0, 1'b1, 4'hF, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    check("idle_load_err", 32'(err), 32'h1);
    check("idle_load_nowrite", 32'(log_addr.size()), 32'h0);
    step(1'b1, 1'b0, 4'h0, 1'b1);
    check("start_clears_err", 32'({busy, err}), 32'h2);

    // full load with occasional gaps between nibbles
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b1, tab[k][3:0], 1'b1);
      if (k % 3 == 1) step(1'b0, 1'b0, 4'h0, 1'b1);
      step(1'b0, 1'b1, tab[k][7:4], 1'b1);
    end
    step(1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    check("full_write_count", 32'(log_addr.size()), 32'd12);
    for (int k = 0; k < 12; k++)
      check($sformatf("full_word%0d", k), 32'({log_addr[k], log_data[k]}), 32'({4'(k), tab[k]}));
    check("full_done_count", 32'(done_cnt), 32'd1);
    check("full_idle", 32'({busy, done, wr_en}), 32'h0);
    check("full_cksum", 32'(cksum), 32'(exp_full_ck));

    // start and load_en together while idle: start taken, no error
    step(1'b1, 1'b1, 4'h5, 1'b1);
    check("start_with_load", 32'({busy, err}), 32'h2);

    // abort after three words and a dangling low nibble
    base = log_addr.size();
    load_word(8'h11);
    load_word(8'h22);
    load_word(8'h33);
    step(1'b0, 1'b1, 4'h5, 1'b1);
    step(1'b1, 1'b0, 4'h0, 1'b1);
    load_word(8'h3C);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    check("abort_count", 32'(log_addr.size()), 32'(base + 4));
    check("abort_word2", 32'({log_addr[base+2], log_data[base+2]}), 32'h233);
    check("abort_restart", 32'({log_addr[base+3], log_data[base+3]}), 32'h03C);

    // ena low freezes the sequence mid-word
    base = log_addr.size();
    step(1'b0, 1'b1, 4'h4, 1'b1);
    step(1'b0, 1'b1, 4'h9, 1'b0);
    step(1'b0, 1'b1, 4'h9, 1'b0);
    step(1'b1, 1'b1, 4'h9, 1'b0);
    check("ena_hold", 32'({busy, wr_en}), 32'h2);
    step(1'b0, 1'b1, 4'h6, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    check("ena_count", 32'(log_addr.size()), 32'(base + 1));
    check("ena_resume", 32'({log_addr[base], log_data[base]}), 32'h164);

    // start beats load_en on the high-nibble cycle
    step(1'b0, 1'b1, 4'h1, 1'b1);
    step(1'b1, 1'b1, 4'h7, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    check("prio_nowrite", 32'(log_addr.size()), 32'(base + 1));

    // async reset between edges after five words
    for (int k = 0; k < 5; k++) load_word(8'(8'h21 + k));
    step(1'b0, 1'b1, 4'h8, 1'b1);
    base = log_addr.size();
    #1 rst_n = 1'b0;
    #1 check("async_reset", 32'(outs()), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1'b0, 1'b1, 4'h2, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    check("reset_nowrite", 32'(log_addr.size()), 32'(base));
    check("reset_idle", 32'({busy, err}), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bnn_load_ctrl.md
BNN_LOAD_CTRL -- requirements
Module: bnn_load_ctrl

Interface
REQ-001 Parameter NUM_NEURONS, default 12, number of 8-bit neuron weight words per load sequence (2..16).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 ena  input  1  design enable; when low, start/load_en ignored, state and outputs held (wr_en and done still forced low).
REQ-005 start  input  1  level-sampled; begins or restarts a load sequence at word 0.
REQ-006 load_en  input  1  nibble strobe; one nibble consumed per sampled-high cycle.
REQ-007 nib_in  input  4  weight nibble, low nibble first, then high nibble.
REQ-008 wr_en  output  1  one-cycle write strobe to weight store.
REQ-009 wr_addr  output  4  neuron index being written.
REQ-010 wr_data  output  8  assembled weight word {high nibble, low nibble}.
REQ-011 busy  output  1  high while a sequence is active (states LO, HI).
REQ-012 done  output  1  one-cycle pulse after final word written.
REQ-013 err  output  1  sticky protocol error flag.
REQ-014 cksum  output  8  running XOR of written words (see Configuration).

Function
REQ-015 States: IDLE, LO, HI, DONE; all outputs registered.
REQ-016 IDLE: ena&start -> LO, word counter=0, err cleared, checksum cleared.
REQ-017 LO: ena&load_en -> latch nib_in into low-nibble buffer, -> HI.
REQ-018 HI: ena&load_en -> next cycle wr_en=1, wr_addr=counter, wr_data={nib_in, buffer}; counter+1; -> DONE if counter was NUM_NEURONS-1, else LO.
REQ-019 Latency: wr_en asserts exactly 1 cycle after the high nibble is sampled; never on consecutive cycles.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE; busy low in DONE.
REQ-021 start sampled in LO or HI (ena high): abort; buffered nibble discarded, no write, counter=0, -> LO; start has priority over load_en same cycle.
REQ-022 ena&load_en in IDLE or DONE without start: nibble ignored, err set to 1 until next accepted start.
REQ-023 ena&start&load_en in IDLE: start taken, load_en ignored, err not set.
REQ-024 Counter never exceeds NUM_NEURONS-1; no wrap-around writes.
REQ-025 wr_addr and wr_data hold last written values between strobes.

Reset
REQ-026 rst_n low, any state, immediately: state=IDLE, counter=0, buffer=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, cksum=0.
REQ-027 Reset mid-sequence: partial sequence lost, no write issued after deassertion.

Configuration
REQ-028 Macro BNN_LOAD_CKSUM_EN defined: cksum updated to cksum XOR wr_data in the same cycle wr_en asserts, cleared on accepted start.
REQ-029 Macro BNN_LOAD_CKSUM_EN undefined: cksum constant 0, no checksum register present.

Verification
REQ-030 Full load, NUM_NEURONS=12: start, nibbles 0x0,0xA then 0x1,0x4 ... -> wr_addr 0 data 0xA0, wr_addr 1 data 0x41, ..., 12 strobes, done pulse after 12th, busy low.
REQ-031 Abort: start, write 3 words, send low nibble 0x5, start again -> no write for 0x5, next write wr_addr=0.
REQ-032 Idle load_en: load_en=1, nib 0xF in IDLE -> no wr_en, err=1; next start -> err=0.
REQ-033 ena gating: ena=0 with load_en pulses mid-sequence -> no state change, no writes; ena=1 resumes at same word.
REQ-034 Async reset after 5 words with rst_n pulse between clock edges -> all outputs 0 immediately, IDLE.
REQ-035 With BNN_LOAD_CKSUM_EN: words 0xA0,0x41 then done (NUM_NEURONS=2) -> cksum=0xE1; without macro cksum=0x00.
